adc_channel_sequencer: RTL and testbench
========================================

Name: adc_channel_sequencer

Overview:
- Frame sequencer on the SAMPLE_CLK side of the ADC sample path.
- Walks the enabled channels in ascending order and issues one conversion request per channel to the ADC core.
- Captures each result and presents it to the frame FIFO write port: RESULT, DONE pulse, one-hot ATMCHSEL, LASTWORD on the final enabled channel.
- Inserts a programmable idle gap between frames and keeps a frame counter.

Parameters:
- NUM_CH, 8, number of channels; fixes the CHEN/ATMCHSEL width. Must be 8 to match the 128-bit FIFO frame.
- CH_IDX_WIDTH, 3, width of ADC_CH, equal to $clog2(NUM_CH).
- GAP_WIDTH, 8, width of FRAMEDIV and the gap counter.
- TIMEOUT_CYCLES, 64, conversion timeout in SAMPLE_CLK cycles; used only with the optional feature.

Ports:
- SAMPLE_CLK  in  1  sole clock; all logic on the rising edge.
- RST_sync  in  1  synchronous, active-high reset.
- ENSAMP_sync  in  1  sampling enable, already synchronous to SAMPLE_CLK.
- CHEN  in  NUM_CH  channel enable mask; bit n enables channel n.
- FRAMEDIV  in  GAP_WIDTH  number of idle cycles inserted after each frame.
- ADC_START  out  1  one-cycle conversion request.
- ADC_CH  out  CH_IDX_WIDTH  index of the channel being converted.
- ADC_EOC  in  1  one-cycle end-of-conversion strobe from the ADC core.
- ADC_RESULT  in  16  conversion result; valid while ADC_EOC=1.
- RESULT  out  16  result word to the FIFO.
- DONE  out  1  one-cycle write strobe to the FIFO.
- ATMCHSEL  out  NUM_CH  one-hot word select; 0 whenever DONE=0.
- LASTWORD  out  1  high with DONE on the last enabled channel of the frame.
- SEQ_ACTIVE  out  1  high in every state except IDLE.
- FRAME_CNT  out  16  completed-frame count; wraps from 16'hFFFF to 0.
- TIMEOUT_ERR  out  1  sticky conversion-timeout flag.

Behaviour:
- Reset: state=IDLE. All of the following are 0: ADC_START, ADC_CH, RESULT, DONE, ATMCHSEL, LASTWORD, SEQ_ACTIVE, FRAME_CNT, TIMEOUT_ERR.
- All outputs are registered.
- States: IDLE, START, CONV, WRITE, GAP.
- IDLE:
  - If ENSAMP_sync=1 and CHEN!=0: latch CHEN into chen_lat, set cur_ch to the lowest set bit, go to START.
  - Otherwise stay in IDLE.
- START: ADC_START=1 and ADC_CH=cur_ch for exactly one cycle, then go to CONV. An ADC_EOC arriving in START is ignored.
- CONV: on ADC_EOC=1, capture ADC_RESULT and go to WRITE. Otherwise wait.
- WRITE (one cycle):
  - DONE=1, RESULT=captured value, ATMCHSEL=1<<cur_ch.
  - LASTWORD=1 iff cur_ch is the highest set bit of chen_lat.
  - If LASTWORD: FRAME_CNT+=1, load gap_cnt=FRAMEDIV, go to GAP.
  - Else: cur_ch = next higher set bit of chen_lat, go to START.
- GAP:
  - If gap_cnt!=0: decrement.
  - If gap_cnt==0: relatch CHEN. If CHEN!=0, go to START with cur_ch = lowest set bit; if CHEN==0, go to IDLE.
  - FRAMEDIV=0 gives zero idle cycles between frames.
- Timing:
  - ENSAMP_sync rising in cycle T: ADC_START is high in cycle T+2.
  - ADC_EOC in cycle E: DONE is high in cycle E+1.
  - DONE to the next ADC_START: 1 cycle.
- CHEN is sampled only at frame start (IDLE exit or GAP exit). Changes mid-frame do not affect the current frame.
- A single-channel mask gives DONE and LASTWORD together on every word.
- ADC_EOC in IDLE, START, WRITE or GAP is ignored.
- ENSAMP_sync=0 in any state:
  - Next state is IDLE and the partial frame is abandoned, with no LASTWORD.
  - ADC_START, DONE, ATMCHSEL and LASTWORD are 0 from that edge on.
  - FRAME_CNT and RESULT hold their values.
- RST_sync overrides everything, including mid-CONV and mid-WRITE.

Optional Feature:
- Macro: SEQ_CONV_TIMEOUT_EN.
- Defined:
  - A timeout counter is cleared on entry to CONV and increments each cycle in CONV.
  - On reaching TIMEOUT_CYCLES without ADC_EOC: go to WRITE with RESULT=16'h8000 and set TIMEOUT_ERR=1.
  - The frame continues normally.
  - TIMEOUT_ERR is cleared only by RST_sync.
- Not defined: CONV waits indefinitely, TIMEOUT_ERR is tied to 0, and no counter logic is present.

Test Plan:
- Reset, then ENSAMP_sync=1, CHEN=8'h05, FRAMEDIV=2, ADC_EOC 3 cycles after each ADC_START:
  - ADC_CH sequence is 0, then 2.
  - DONE with ATMCHSEL=8'h01 and LASTWORD=0, then DONE with ATMCHSEL=8'h04 and LASTWORD=1.
  - FRAME_CNT=1.
  - Next ADC_START exactly 3 cycles after the LASTWORD cycle.
- CHEN=8'h80, FRAMEDIV=0: every DONE carries LASTWORD=1 and ATMCHSEL=8'h80; frames run back to back.
- CHEN=8'hFF, with CHEN changed to 8'h01 mid-frame: the current frame still emits 8 words ending with ATMCHSEL=8'h80 and LASTWORD=1; the next frame emits one word, ATMCHSEL=8'h01.
- ENSAMP_sync dropped during CONV of channel 3 (CHEN=8'hFF): SEQ_ACTIVE=0 next cycle; no DONE even if ADC_EOC arrives later; FRAME_CNT unchanged.
- With SEQ_CONV_TIMEOUT_EN and ADC_EOC never asserted: DONE after TIMEOUT_CYCLES with RESULT=16'h8000 and TIMEOUT_ERR=1; TIMEOUT_ERR stays 1 until RST_sync. Without the macro: no DONE and TIMEOUT_ERR=0.
- FRAME_CNT preloaded via 65535 frames (CHEN=8'h01, FRAMEDIV=0): the next LASTWORD wraps FRAME_CNT to 0; CHEN=0 at GAP exit returns the block to IDLE.

Source files
------------

// File: rtl/adc_channel_sequencer.sv
// rtl/adc_channel_sequencer.sv - ADC frame channel sequencer feeding the frame FIFO write port
// Optional conversion timeout is enabled by defining SEQ_CONV_TIMEOUT_EN.
module adc_channel_sequencer #(
  parameter int NUM_CH         = 8,
  parameter int CH_IDX_WIDTH   = 3,
  parameter int GAP_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    SAMPLE_CLK,
  input  logic                    RST_sync,
  input  logic                    ENSAMP_sync,
  input  logic [NUM_CH-1:0]       CHEN,
  input  logic [GAP_WIDTH-1:0]    FRAMEDIV,
  output logic                    ADC_START,
  output logic [CH_IDX_WIDTH-1:0] ADC_CH,
  input  logic                    ADC_EOC,
  input  logic [15:0]             ADC_RESULT,
  output logic [15:0]             RESULT,
  output logic                    DONE,
  output logic [NUM_CH-1:0]       ATMCHSEL,
  output logic                    LASTWORD,
  output logic                    SEQ_ACTIVE,
  output logic [15:0]             FRAME_CNT,
  output logic                    TIMEOUT_ERR
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_CONV, S_WRITE, S_GAP} state_t;

  state_t                  state;
  logic [NUM_CH-1:0]       chen_lat;
  logic [CH_IDX_WIDTH-1:0] cur_ch;
  logic [GAP_WIDTH-1:0]    gap_cnt;
  logic [CH_IDX_WIDTH-1:0] first_ch;
  logic [CH_IDX_WIDTH-1:0] next_ch;
  logic [CH_IDX_WIDTH-1:0] last_ch;
  logic                    conv_timeout;

  if (TIMEOUT_CYCLES < 1 || CH_IDX_WIDTH != $clog2(NUM_CH)) begin : g_param_check
    $error("adc_channel_sequencer: inconsistent parameters");
  end

  function automatic logic [CH_IDX_WIDTH-1:0] lowest_ch(input logic [NUM_CH-1:0] mask);
    lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask[i]) lowest_ch = CH_IDX_WIDTH'(i);
  endfunction

  function automatic logic [CH_IDX_WIDTH-1:0] highest_ch(input logic [NUM_CH-1:0] mask);
    highest_ch = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (mask[i]) highest_ch = CH_IDX_WIDTH'(i);
  endfunction

  function automatic logic [CH_IDX_WIDTH-1:0] next_set_ch(input logic [NUM_CH-1:0] mask,
                                                          input logic [CH_IDX_WIDTH-1:0] cur);
    next_set_ch = cur;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask[i] && i > int'(cur)) next_set_ch = CH_IDX_WIDTH'(i);
  endfunction

  assign first_ch = lowest_ch(CHEN);
  assign next_ch  = next_set_ch(chen_lat, cur_ch);
  assign last_ch  = highest_ch(chen_lat);

`ifdef SEQ_CONV_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign conv_timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counter idles at zero outside CONV, so it restarts on every CONV entry.
  always_ff @(posedge SAMPLE_CLK) begin
    if (RST_sync) begin
      to_cnt      <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      to_cnt <= (state == S_CONV) ? to_cnt + TO_W'(1) : '0;
      if (ENSAMP_sync && state == S_CONV && !ADC_EOC && conv_timeout)
        TIMEOUT_ERR <= 1'b1;
    end
  end
`else
  assign conv_timeout = 1'b0;
  assign TIMEOUT_ERR  = 1'b0;
`endif

  always_ff @(posedge SAMPLE_CLK) begin
    if (RST_sync) begin
      state      <= S_IDLE;
      chen_lat   <= '0;
      cur_ch     <= '0;
      gap_cnt    <= '0;
      ADC_START  <= 1'b0;
      ADC_CH     <= '0;
      RESULT     <= '0;
      DONE       <= 1'b0;
      ATMCHSEL   <= '0;
      LASTWORD   <= 1'b0;
      SEQ_ACTIVE <= 1'b0;
      FRAME_CNT  <= '0;
    end else if (!ENSAMP_sync) begin
      state      <= S_IDLE;
      ADC_START  <= 1'b0;
      DONE       <= 1'b0;
      ATMCHSEL   <= '0;
      LASTWORD   <= 1'b0;
      SEQ_ACTIVE <= 1'b0;
    end else begin
      ADC_START <= 1'b0;
      DONE      <= 1'b0;
      ATMCHSEL  <= '0;
      LASTWORD  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (CHEN != '0) begin
            chen_lat   <= CHEN;
            cur_ch     <= first_ch;
            ADC_CH     <= first_ch;
            SEQ_ACTIVE <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          // Entry from IDLE arrives with ADC_START low: spend one arming cycle first.
          if (!ADC_START) ADC_START <= 1'b1;
          else            state     <= S_CONV;
        end
        S_CONV: begin
          if (ADC_EOC || conv_timeout) begin
            RESULT   <= ADC_EOC ? ADC_RESULT : 16'h8000;
            DONE     <= 1'b1;
            ATMCHSEL <= NUM_CH'(1) << cur_ch;
            LASTWORD <= (cur_ch == last_ch);
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (LASTWORD) begin
            FRAME_CNT <= FRAME_CNT + 16'd1;
            if (FRAMEDIV != '0) begin
              gap_cnt <= FRAMEDIV - GAP_WIDTH'(1);
              state   <= S_GAP;
            end else begin
              chen_lat <= CHEN;
              if (CHEN != '0) begin
                cur_ch    <= first_ch;
                ADC_CH    <= first_ch;
                ADC_START <= 1'b1;
                state     <= S_START;
              end else begin
                SEQ_ACTIVE <= 1'b0;
                state      <= S_IDLE;
              end
            end
          end else begin
            cur_ch    <= next_ch;
            ADC_CH    <= next_ch;
            ADC_START <= 1'b1;
            state     <= S_START;
          end
        end
        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end else begin
            chen_lat <= CHEN;
            if (CHEN != '0) begin
              cur_ch    <= first_ch;
              ADC_CH    <= first_ch;
              ADC_START <= 1'b1;
              state     <= S_START;
            end else begin
              SEQ_ACTIVE <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// tb/tb_adc_channel_sequencer.sv - directed self-checking bench for adc_channel_sequencer
module tb_adc_channel_sequencer;

  localparam int TIMEOUT_CYCLES = 64;

  logic        SAMPLE_CLK = 1'b0;
  logic        RST_sync;
  logic        ENSAMP_sync;
  logic [7:0]  CHEN;
  logic [7:0]  FRAMEDIV;
  logic        ADC_START;
  logic [2:0]  ADC_CH;
  logic        ADC_EOC;
  logic [15:0] ADC_RESULT;
  logic [15:0] RESULT;
  logic        DONE;
  logic [7:0]  ATMCHSEL;
  logic        LASTWORD;
  logic        SEQ_ACTIVE;
  logic [15:0] FRAME_CNT;
  logic        TIMEOUT_ERR;

  int n_assert = 0;
  int n_fail   = 0;
  int done_at;

  adc_channel_sequencer #(
    .NUM_CH(8), .CH_IDX_WIDTH(3), .GAP_WIDTH(8), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .SAMPLE_CLK (SAMPLE_CLK),
    .RST_sync   (RST_sync),
    .ENSAMP_sync(ENSAMP_sync),
    .CHEN       (CHEN),
    .FRAMEDIV   (FRAMEDIV),
    .ADC_START  (ADC_START),
    .ADC_CH     (ADC_CH),
    .ADC_EOC    (ADC_EOC),
    .ADC_RESULT (ADC_RESULT),
    .RESULT     (RESULT),
    .DONE       (DONE),
    .ATMCHSEL   (ATMCHSEL),
    .LASTWORD   (LASTWORD),
    .SEQ_ACTIVE (SEQ_ACTIVE),
    .FRAME_CNT  (FRAME_CNT),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 SAMPLE_CLK = ~SAMPLE_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge where ADC_START must be high; EOC answers 3 cycles later.
  task automatic do_word(input logic [2:0] ch, input logic [15:0] res, input logic last);
    chk("adc_start", ADC_START, 1);
    chk("adc_ch", ADC_CH, ch);
    repeat (3) @(negedge SAMPLE_CLK);
    ADC_EOC    = 1'b1;
    ADC_RESULT = res;
    @(negedge SAMPLE_CLK);
    ADC_EOC = 1'b0;
    chk("done", DONE, 1);
    chk("result", RESULT, res);
    chk("atmchsel", ATMCHSEL, 32'(8'h01 << ch));
    chk("lastword", LASTWORD, last);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (ADC_START !== 1'b1 && n < 20) begin
      @(negedge SAMPLE_CLK);
      n++;
    end
    chk(tag, ADC_START, 1);
  endtask

  initial begin
    RST_sync = 1'b1; ENSAMP_sync = 1'b0; CHEN = 8'h00; FRAMEDIV = 8'd0;
    ADC_EOC = 1'b0; ADC_RESULT = 16'h0000;
    repeat (3) @(negedge SAMPLE_CLK);
    chk("rst_adc_start", ADC_START, 0);
    chk("rst_adc_ch", ADC_CH, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_done", DONE, 0);
    chk("rst_atmchsel", ATMCHSEL, 0);
    chk("rst_lastword", LASTWORD, 0);
    chk("rst_seq_active", SEQ_ACTIVE, 0);
    chk("rst_frame_cnt", FRAME_CNT, 0);
    chk("rst_timeout_err", TIMEOUT_ERR, 0);
    RST_sync = 1'b0;
    @(negedge SAMPLE_CLK);

    // Frame of channels 0 and 2 with a 2-cycle gap
    ENSAMP_sync = 1'b1; CHEN = 8'h05; FRAMEDIV = 8'd2;
    @(negedge SAMPLE_CLK);
    chk("arm_no_start", ADC_START, 0);
    chk("arm_active", SEQ_ACTIVE, 1);
    @(negedge SAMPLE_CLK);
    do_word(3'd0, 16'h1234, 1'b0);
    @(negedge SAMPLE_CLK);
    do_word(3'd2, 16'hBEEF, 1'b1);
    CHEN = 8'h80;
    @(negedge SAMPLE_CLK);
    chk("gap1_frame_cnt", FRAME_CNT, 1);
    chk("gap1_done", DONE, 0);
    chk("gap1_atmchsel", ATMCHSEL, 0);
    chk("gap1_start", ADC_START, 0);
    chk("gap1_active", SEQ_ACTIVE, 1);
    @(negedge SAMPLE_CLK);
    chk("gap2_start", ADC_START, 0);
    @(negedge SAMPLE_CLK);

    // Single channel 7, frames back to back
    FRAMEDIV = 8'd0;
    do_word(3'd7, 16'h7001, 1'b1);
    @(negedge SAMPLE_CLK);
    chk("ch7_frame_cnt2", FRAME_CNT, 2);
    do_word(3'd7, 16'h7002, 1'b1);
    CHEN = 8'hFF;
    @(negedge SAMPLE_CLK);
    chk("ch7_frame_cnt3", FRAME_CNT, 3);

    // All channels, mask changed mid-frame
    for (int i = 0; i < 8; i++) begin
      do_word(3'(i), 16'h3000 + 16'(i), (i == 7));
      if (i == 0) CHEN = 8'h01;
      @(negedge SAMPLE_CLK);
    end
    chk("ff_frame_cnt", FRAME_CNT, 4);
    do_word(3'd0, 16'h4444, 1'b1);
    CHEN = 8'hFF;
    @(negedge SAMPLE_CLK);
    chk("one_frame_cnt", FRAME_CNT, 5);

    // Abort during CONV of channel 3
    for (int i = 0; i < 3; i++) begin
      do_word(3'(i), 16'h6000 + 16'(i), 1'b0);
      @(negedge SAMPLE_CLK);
    end
    chk("abort_start", ADC_START, 1);
    chk("abort_ch", ADC_CH, 3);
    @(negedge SAMPLE_CLK);
    ENSAMP_sync = 1'b0;
    @(negedge SAMPLE_CLK);
    chk("abort_active", SEQ_ACTIVE, 0);
    ADC_EOC = 1'b1; ADC_RESULT = 16'hDEAD;
    @(negedge SAMPLE_CLK);
    ADC_EOC = 1'b0;
    chk("abort_done", DONE, 0);
    chk("abort_atmchsel", ATMCHSEL, 0);
    chk("abort_start_low", ADC_START, 0);
    chk("abort_frame_cnt", FRAME_CNT, 5);
    chk("abort_result_hold", RESULT, 16'h6002);

    // Conversion that never ends
    CHEN = 8'h01; FRAMEDIV = 8'd0; ENSAMP_sync = 1'b1;
    wait_start("to_start");
    done_at = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge SAMPLE_CLK);
      if (DONE === 1'b1 && done_at == 0) done_at = i;
    end
`ifdef SEQ_CONV_TIMEOUT_EN
    chk("to_done_latency", done_at, TIMEOUT_CYCLES + 1);
    chk("to_result", RESULT, 16'h8000);
    chk("to_err_sticky", TIMEOUT_ERR, 1);
`else
    chk("to_no_done", done_at, 0);
    chk("to_err_zero", TIMEOUT_ERR, 0);
`endif
    RST_sync = 1'b1; ENSAMP_sync = 1'b0;
    @(negedge SAMPLE_CLK);
    RST_sync = 1'b0;
    chk("rst2_timeout_err", TIMEOUT_ERR, 0);
    chk("rst2_frame_cnt", FRAME_CNT, 0);
    chk("rst2_active", SEQ_ACTIVE, 0);

    // Frame counter wrap, then CHEN=0 at frame end returns to IDLE
    force dut.FRAME_CNT = 16'hFFFF;
    @(negedge SAMPLE_CLK);
    release dut.FRAME_CNT;
    CHEN = 8'h01; FRAMEDIV = 8'd0; ENSAMP_sync = 1'b1;
    wait_start("wrap_start");
    do_word(3'd0, 16'h5555, 1'b1);
    CHEN = 8'h00;
    @(negedge SAMPLE_CLK);
    chk("wrap_frame_cnt", FRAME_CNT, 0);
    chk("wrap_idle_active", SEQ_ACTIVE, 0);
    chk("wrap_idle_start", ADC_START, 0);
    @(negedge SAMPLE_CLK);
    chk("wrap_stay_idle", SEQ_ACTIVE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
